decimal_digit_sprite_reader: RTL and testbench



---
 rtl/digit_sprite_pkg.sv | 41 ++++
 rtl/bin2bcd_seq.sv | 75 +++++++
 rtl/decimal_digit_sprite_reader.sv | 104 ++++++++++
 tb/tb_decimal_digit_sprite_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_sprite_pkg.sv
// Shared types and constants for the decimal digit sprite reader and its
// binary-to-BCD converter.
package digit_sprite_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 16;
  localparam int DIGIT_H    = 16;
  localparam int ROM_ADDR_W = 12;
  localparam int RGB_W      = 12;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = NUM_DIGITS * 4;

  localparam int COL_W     = $clog2(DIGIT_W);
  localparam int ROW_W     = $clog2(DIGIT_H);
  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam int COL_LSB   = 0;
  localparam int ROW_LSB   = COL_LSB + COL_W;
  localparam int DIGIT_LSB = ROW_LSB + ROW_W;

  typedef logic [3:0]       bcd_t;
  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t              TRANSPARENT = 12'h000;
  localparam logic [BIN_W-1:0]  BIN_MAX     = 14'd9999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_t;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary (saturated to 9999) to
// four packed BCD digits, one shift per clock.
module bin2bcd_seq
  import digit_sprite_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output conv_state_t      state
);

  // Handshake: start is accepted only in IDLE (ignored otherwise, never
  // queued); busy is high from the cycle after acceptance through COMMIT;
  // done pulses for the single COMMIT cycle, during which bcd is final.

  localparam logic [3:0] LAST_SHIFT = 4'(BIN_W - 1);

  conv_state_t      next_state;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0] adj;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= next_state;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    next_state = state;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    adj        = dabble_adjust(bcd_q);
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          bin_d      = (value > BIN_MAX) ? BIN_MAX : value;
          bcd_d      = '0;
          cnt_d      = '0;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == LAST_SHIFT) next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        done       = 1'b1;
        cnt_d      = '0;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/decimal_digit_sprite_reader.sv
// Renders a four-digit decimal score from the digit-sprite ROM in raster order.
// Optional macro LEADING_ZERO_BLANK_EN suppresses digits left of the MS nonzero digit.
module decimal_digit_sprite_reader
  import digit_sprite_pkg::*;
#(
  parameter logic [9:0] X0 = 10'd560,
  parameter logic [9:0] Y0 = 10'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value_in,
  input  logic        value_load,
  output logic        busy,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] rgb_out,
  output logic        sprite_on
);

  localparam int         DX_W  = COL_W + IDX_W;
  localparam logic [9:0] X_END = X0 + 10'(NUM_DIGITS * DIGIT_W);
  localparam logic [9:0] Y_END = Y0 + 10'(DIGIT_H);

  conv_state_t          conv_state;
  logic                 conv_start;
  logic                 conv_done;
  logic [BCD_W-1:0]     conv_bcd;
  logic [BCD_W-1:0]     disp_bcd;
  logic [NUM_DIGITS-1:0] blank, blank_next;

  assign conv_start = value_load && (conv_state == ST_IDLE);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (value_in),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .state (conv_state)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Index 0 is the leftmost (most significant) digit; the LS digit never blanks.
  always_comb begin
    logic lead;
    blank_next = '0;
    lead       = 1'b1;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      lead          = lead && (conv_bcd[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
      blank_next[i] = lead;
    end
  end
`else
  assign blank_next = '0;
`endif

  logic [DX_W-1:0]  dx;
  logic [IDX_W-1:0] digit_idx;
  logic [IDX_W-1:0] digit_sel;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  bcd_t             digit_val;
  logic             in_region;
  logic             visible;
  logic             region_d;
  logic             opaque;

  assign in_region = video_on && (pixel_x >= X0) && (pixel_x < X_END)
                  && (pixel_y >= Y0) && (pixel_y < Y_END);
  assign dx        = DX_W'(pixel_x - X0);
  assign row       = ROW_W'(pixel_y - Y0);
  assign col       = dx[COL_W-1:0];
  assign digit_idx = dx[DX_W-1:COL_W];
  // Leftmost digit sits in the top nibble, so the nibble index is the complement.
  assign digit_sel = ~digit_idx;
  assign digit_val = disp_bcd[{digit_sel, 2'b00} +: 4];
  assign rom_addr  = in_region ? {digit_val, row, col} : '0;
  assign visible   = in_region && !blank[digit_idx];
  assign opaque    = region_d && (rom_data != TRANSPARENT);

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_bcd  <= '0;
      blank     <= '0;
      region_d  <= 1'b0;
      sprite_on <= 1'b0;
      rgb_out   <= '0;
    end else begin
      if (conv_done) begin
        disp_bcd <= conv_bcd;
        blank    <= blank_next;
      end
      region_d  <= visible;
      sprite_on <= opaque;
      rgb_out   <= opaque ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_decimal_digit_sprite_reader.sv
// Self-checking bench for decimal_digit_sprite_reader with a registered ROM model
// and an arithmetic reference model of the displayed digits.
module tb_decimal_digit_sprite_reader;

  localparam int X0 = 560;
  localparam int Y0 = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] value_in = '0;
  logic        value_load = 1'b0;
  logic        busy;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        video_on = 1'b0;
  logic [11:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [11:0] rgb_out;
  logic        sprite_on;

  int          n_checks = 0;
  int          n_pass = 0;
  int          model_val = 0;
  logic [12:0] exp_q[$];

  typedef struct {
    int          value;
    logic [15:0] bcd;
  } vec_t;
  vec_t vecs[8];

  decimal_digit_sprite_reader dut (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .value_load (value_load),
    .busy       (busy),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rgb_out    (rgb_out),
    .sprite_on  (sprite_on)
  );

  always #5 clk = ~clk;

  // ROM contents: column 15 of every glyph is transparent, everything else
  // is a nonzero colour derived from {digit,row,col}.
  function automatic logic [11:0] rom_color(input logic [11:0] a);
    if (a[3:0] == 4'd15) return 12'h000;
    return {a[11:8] ^ 4'hA, a[7:4], a[3:0]};
  endfunction

  always @(posedge clk) rom_data <= rom_color(rom_addr);

  function automatic int pow10(input int e);
    case (e)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic int digit_of(input int n, input int idx);
    return (n / pow10(3 - idx)) % 10;
  endfunction

  function automatic bit blanked(input int n, input int idx);
`ifdef LEADING_ZERO_BLANK_EN
    return (idx < 3) && (n < pow10(3 - idx));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [12:0] model_pixel(input int x, input int y, input bit von);
    int dx, dy, idx;
    logic [11:0] c;
    dx = x - X0;
    dy = y - Y0;
    if (!von || dx < 0 || dx >= 64 || dy < 0 || dy >= 16) return 13'h0;
    idx = dx / 16;
    if (blanked(model_val, idx)) return 13'h0;
    c = rom_color({4'(digit_of(model_val, idx)), 4'(dy), 4'(dx % 16)});
    return (c != 12'h000) ? {1'b1, c} : 13'h0;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic drive_pixel_exp(input int x, input int y, input bit von, input logic [12:0] e_in);
    logic [12:0] e;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    exp_q.push_back(e_in);
    @(posedge clk); #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("sprite_on", int'(sprite_on), int'(e[12]));
      check("rgb_out", int'(rgb_out), int'(e[11:0]));
    end
  endtask

  task automatic drive_pixel(input int x, input int y, input bit von);
    drive_pixel_exp(x, y, von, model_pixel(x, y, von));
  endtask

  task automatic drain();
    drive_pixel(0, 0, 1'b0);
    drive_pixel(0, 0, 1'b0);
    exp_q.delete();
  endtask

  task automatic render_digits();
    for (int i = 0; i < 4; i++) begin
      drive_pixel(X0 + 16*i,      Y0,      1'b1);
      drive_pixel(X0 + 16*i + 7,  Y0 + 5,  1'b1);
      drive_pixel(X0 + 16*i + 15, Y0 + 15, 1'b1);
      drive_pixel(X0 + 16*i + 3,  Y0 + 15, 1'b1);
    end
    drain();
  endtask

  // Strobe a load, check busy across the conversion, optionally fire a
  // second strobe while busy (which must have no effect).
  task automatic load_and_wait(input int v, input int extra_at, input int extra_v);
    value_in   = 14'(v);
    value_load = 1'b1;
    @(posedge clk); #1;
    value_load = 1'b0;
    for (int c = 0; c < 15; c++) begin
      check("busy_high", int'(busy), 1);
      if (c == extra_at) begin
        value_in   = 14'(extra_v);
        value_load = 1'b1;
      end
      @(posedge clk); #1;
      value_load = 1'b0;
    end
    check("busy_low", int'(busy), 0);
    model_val = (v > 9999) ? 9999 : v;
  endtask

  initial begin
    vecs[0] = '{0,     16'h0000};
    vecs[1] = '{1234,  16'h1234};
    vecs[2] = '{9999,  16'h9999};
    vecs[3] = '{10000, 16'h9999};
    vecs[4] = '{16383, 16'h9999};
    vecs[5] = '{42,    16'h0042};
    vecs[6] = '{1000,  16'h1000};
    vecs[7] = '{5,     16'h0005};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_busy", int'(busy), 0);
    check("reset_rgb", int'(rgb_out), 0);
    check("reset_sprite_on", int'(sprite_on), 0);
    render_digits();

    // First load: explicit two-cycle pipeline check on digit '2', row 0, col 0.
    load_and_wait(1234, -1, 0);
    pixel_x = 10'(X0 + 16); pixel_y = 10'(Y0); video_on = 1'b1;
    @(posedge clk); #1;
    check("lat_n1_sprite_on", int'(sprite_on), 0);
    video_on = 1'b0;
    @(posedge clk); #1;
    check("lat_n2_rgb", int'(rgb_out), int'(rom_color(12'h200)));
    check("lat_n2_sprite_on", int'(sprite_on), 1);
    @(posedge clk); #1;
    check("lat_n3_rgb", int'(rgb_out), 0);
    drain();

    // Saturation.
    load_and_wait(12000, -1, 0);
    render_digits();

    // Strobe while busy is ignored.
    load_and_wait(567, 5, 888);
    render_digits();
    check("busy_after_ignored", int'(busy), 0);

    // Horizontal sweep across the field on the last row, plus row boundaries.
    load_and_wait(1234, -1, 0);
    for (int x = X0 - 1; x <= X0 + 64; x++) drive_pixel(x, Y0 + 15, 1'b1);
    drive_pixel(X0 + 1, Y0 + 16, 1'b1);
    drive_pixel(X0 + 1, Y0 - 1,  1'b1);
    drive_pixel(X0 + 1, Y0,      1'b0);
    drain();

    // Reset in the middle of a conversion.
    value_in   = 14'd4321;
    value_load = 1'b1;
    @(posedge clk); #1;
    value_load = 1'b0;
    for (int c = 0; c < 7; c++) begin
      check("busy_conv", int'(busy), 1);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("busy_after_reset", int'(busy), 0);
    model_val = 0;
    render_digits();
    check("busy_stays_idle", int'(busy), 0);
    load_and_wait(42, -1, 0);
    render_digits();

    // Table-driven: expected digits come straight from the table.
    foreach (vecs[k]) begin
      load_and_wait(vecs[k].value, -1, 0);
      for (int i = 0; i < 4; i++) begin
        logic [3:0]  d;
        logic [11:0] c;
        bit          lead, blank;
        lead = 1'b1;
        for (int j = 0; j <= i; j++) lead = lead && (vecs[k].bcd[(3-j)*4 +: 4] == 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
        blank = lead && (i < 3);
`else
        blank = 1'b0 && lead;
`endif
        d = vecs[k].bcd[(3-i)*4 +: 4];
        c = rom_color({d, 4'd2, 4'd3});
        drive_pixel_exp(X0 + 16*i + 3, Y0 + 2, 1'b1, blank ? 13'h0 : {1'b1, c});
      end
      drain();
    end

    // Randomized loads and pixels against the arithmetic model.
    for (int it = 0; it < 30; it++) begin
      int v;
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                      : int'($urandom_range(0, 9999));
      load_and_wait(v, -1, 0);
      for (int p = 0; p < 24; p++) begin
        drive_pixel(int'($urandom_range(X0 - 4, X0 + 68)),
                    int'($urandom_range(Y0 - 2, Y0 + 17)),
                    $urandom_range(0, 7) != 0);
      end
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
